// File: rtl/rvj1_defines.sv
// Shared types for the RVJ1 pipeline controller: data widths, LSU commands,
// controller FSM states and trap causes.
package rvj1_defines;

    localparam int XLEN  = 32;
    localparam int RALEN = 5;

    // Bit 3 of the LSU command marks a write (store).
    typedef enum logic [3:0] {
        LSU_LB  = 4'h0,
        LSU_LH  = 4'h1,
        LSU_LW  = 4'h2,
        LSU_LBU = 4'h4,
        LSU_LHU = 4'h5,
        LSU_SB  = 4'h8,
        LSU_SH  = 4'h9,
        LSU_SW  = 4'hA
    } lsu_ctrl_e;

    typedef enum logic [2:0] {
        RESET,
        BOOT,
        RUN,
        LOAD_WAIT,
        TRAP
    } rvj1_ctrl_fsm_e;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        MISALIGN   = 2'd1,
        LD_TIMEOUT = 2'd2
    } trap_cause_e;

    function automatic logic is_store(input lsu_ctrl_e cmd);
        return cmd[3];
    endfunction

endpackage

// File: rtl/rvj1_pipe_ctrl_if.sv
// Decoder/ALU/LSU-facing signal bundle of the RVJ1 pipeline controller.
// The master side drives the pipeline status, the slave side is the controller.
interface rvj1_pipe_ctrl_if;
    import rvj1_defines::*;

    logic [RALEN-1:0] rf_addr_a_i;
    logic [RALEN-1:0] rf_addr_b_i;
    logic             rpa_used_i;
    logic             rpb_used_i;
    logic [RALEN-1:0] rd_addr_i;
    logic             rd_we_i;
    lsu_ctrl_e        lsu_cmd_i;
    logic             lsu_ctrl_valid_i;
    logic             lsu_ready_i;
    logic             instr_issued_i;
    logic             jmp_req_i;
    logic [XLEN-1:0]  jmp_tgt_i;

    logic             stall_o;
    logic [XLEN-1:0]  program_counter_o;
    logic             jmp_addr_valid_o;
    logic [XLEN-1:0]  jmp_addr_o;
    logic             trap_o;
    logic [1:0]       trap_cause_o;

    modport master (
        output rf_addr_a_i, rf_addr_b_i, rpa_used_i, rpb_used_i, rd_addr_i, rd_we_i,
               lsu_cmd_i, lsu_ctrl_valid_i, lsu_ready_i, instr_issued_i, jmp_req_i, jmp_tgt_i,
        input  stall_o, program_counter_o, jmp_addr_valid_o, jmp_addr_o, trap_o, trap_cause_o
    );

    modport slave (
        input  rf_addr_a_i, rf_addr_b_i, rpa_used_i, rpb_used_i, rd_addr_i, rd_we_i,
               lsu_cmd_i, lsu_ctrl_valid_i, lsu_ready_i, instr_issued_i, jmp_req_i, jmp_tgt_i,
        output stall_o, program_counter_o, jmp_addr_valid_o, jmp_addr_o, trap_o, trap_cause_o
    );

endinterface

// File: rtl/rvj1_pipe_ctrl_scoreboard.sv
// In-flight destination tracker: a HAZ_DEPTH-deep shift register of {valid, rd}
// that shifts every cycle and flags read-after-write hazards on the two sources.
module rvj1_scoreboard
    import rvj1_defines::*;
#(
    parameter int HAZ_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush,
    input  logic             ins_valid,
    input  logic [RALEN-1:0] ins_rd,
    input  logic [RALEN-1:0] rs_a,
    input  logic             rs_a_used,
    input  logic [RALEN-1:0] rs_b,
    input  logic             rs_b_used,
    output logic             hazard
);

    logic [HAZ_DEPTH-1:0] vld;
    logic [RALEN-1:0]     rd [HAZ_DEPTH];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            vld[0] <= ins_valid;
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // Register tags need no reset: they are only looked at through vld.
    always_ff @(posedge clk_i) begin
        rd[0] <= ins_rd;
        for (int i = 1; i < HAZ_DEPTH; i++) begin
            rd[i] <= rd[i-1];
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (vld[i] && rs_a_used && (rs_a != '0) && (rd[i] == rs_a)) hazard = 1'b1;
            if (vld[i] && rs_b_used && (rs_b != '0) && (rd[i] == rs_b)) hazard = 1'b1;
        end
    end

endmodule

// File: rtl/rvj1_pipe_ctrl.sv
// RVJ1 pipeline controller: boot/trap sequencing, PC, hazard stall, load wait.
// Optional load-wait timeout trap is built when RVJ1_LOAD_TIMEOUT_EN is defined.
module rvj1_pipe_ctrl
    import rvj1_defines::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR    = 32'h8000_0000,
    parameter logic [XLEN-1:0] TRAP_ADDR    = 32'h8000_0100,
    parameter int              HAZ_DEPTH    = 2,
    parameter int              LOAD_TIMEOUT = 16
) (
    input logic             clk_i,
    input logic             rstn_i,
    rvj1_pipe_ctrl_if.slave bus
);

    rvj1_ctrl_fsm_e  state;
    logic [XLEN-1:0] pc;
    trap_cause_e     cause;
    logic            redir_q;
    logic [XLEN-1:0] redir_addr_q;
    logic            trap_q;

    logic in_run, hazard, stall, issue_ok, store_vld, load_issue;
    logic jump_ok, misalign, timeout_hit, flush, ins_valid;

    assign in_run     = (state == RUN);
    assign store_vld  = bus.lsu_ctrl_valid_i && is_store(bus.lsu_cmd_i);
    assign stall      = hazard || !in_run;
    assign issue_ok   = bus.instr_issued_i && !stall;
    assign load_issue = issue_ok && bus.lsu_ctrl_valid_i && !is_store(bus.lsu_cmd_i);
    assign jump_ok    = in_run && bus.jmp_req_i && (bus.jmp_tgt_i[1:0] == 2'b00);
    assign misalign   = in_run && bus.jmp_req_i && (bus.jmp_tgt_i[1:0] != 2'b00);
    assign flush      = jump_ok || misalign || timeout_hit || (state == TRAP);
    assign ins_valid  = issue_ok && bus.rd_we_i && (bus.rd_addr_i != '0);

`ifdef RVJ1_LOAD_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_cnt <= '0;
        end else if (state != LOAD_WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // The last counted wait cycle without ready triggers the trap; ready wins.
    assign timeout_hit = (state == LOAD_WAIT) && !bus.lsu_ready_i &&
                         (tmo_cnt == 8'(LOAD_TIMEOUT - 1));
`else
    localparam int unused_load_timeout = LOAD_TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    rvj1_scoreboard #(
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .flush     (flush),
        .ins_valid (ins_valid),
        .ins_rd    (bus.rd_addr_i),
        .rs_a      (bus.rf_addr_a_i),
        .rs_a_used (bus.rpa_used_i),
        .rs_b      (bus.rf_addr_b_i),
        .rs_b_used (bus.rpb_used_i || store_vld),
        .hazard    (hazard)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= RESET;
            pc           <= BOOT_ADDR;
            cause        <= NONE;
            redir_q      <= 1'b0;
            redir_addr_q <= BOOT_ADDR;
            trap_q       <= 1'b0;
        end else begin
            redir_q <= 1'b0;
            trap_q  <= 1'b0;
            case (state)
                RESET: begin
                    state        <= BOOT;
                    redir_q      <= 1'b1;
                    redir_addr_q <= BOOT_ADDR;
                end
                BOOT: state <= RUN;
                RUN: begin
                    if (misalign) begin
                        state        <= TRAP;
                        pc           <= TRAP_ADDR;
                        cause        <= MISALIGN;
                        redir_q      <= 1'b1;
                        redir_addr_q <= TRAP_ADDR;
                        trap_q       <= 1'b1;
                    end else if (jump_ok) begin
                        // A redirect overrides whatever issued alongside it.
                        pc <= bus.jmp_tgt_i;
                    end else begin
                        if (issue_ok) pc <= pc + XLEN'(4);
                        if (load_issue) state <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    if (bus.lsu_ready_i) begin
                        state <= RUN;
                    end else if (timeout_hit) begin
                        state        <= TRAP;
                        pc           <= TRAP_ADDR;
                        cause        <= LD_TIMEOUT;
                        redir_q      <= 1'b1;
                        redir_addr_q <= TRAP_ADDR;
                        trap_q       <= 1'b1;
                    end
                end
                TRAP:    state <= RUN;
                default: state <= RESET;
            endcase
        end
    end

    assign bus.stall_o           = stall;
    assign bus.program_counter_o = pc;
    assign bus.jmp_addr_valid_o  = redir_q || jump_ok;
    assign bus.jmp_addr_o        = jump_ok ? bus.jmp_tgt_i : redir_addr_q;
    assign bus.trap_o            = trap_q;
    assign bus.trap_cause_o      = cause;

endmodule

// File: tb/tb_rvj1_pipe_ctrl.sv
// Directed bench for rvj1_pipe_ctrl with a cycle-level reference model checked
// on every falling edge, plus literal expectations. Honours RVJ1_LOAD_TIMEOUT_EN.
module tb_rvj1_pipe_ctrl;
    import rvj1_defines::*;

    localparam logic [31:0] BOOT = 32'h8000_0000;
    localparam logic [31:0] TRAPA = 32'h8000_0100;
    localparam int HAZ = 2;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    rvj1_pipe_ctrl_if bus();

    rvj1_pipe_ctrl #(
        .BOOT_ADDR    (BOOT),
        .TRAP_ADDR    (TRAPA),
        .HAZ_DEPTH    (HAZ),
        .LOAD_TIMEOUT (TMO)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_age;
    bit          m_load;
    int          m_wait;
    bit          m_trap_now;
    logic [31:0] m_pc, m_redir;
    logic [1:0]  m_cause;
    int          m_hist[$];

    always @(negedge clk) begin
        if (!rstn) begin
            m_age = 0; m_load = 0; m_wait = 0; m_trap_now = 0;
            m_pc = BOOT; m_redir = BOOT; m_cause = 2'd0;
            m_hist.delete();
            check("mdl_rst_stall", 32'(bus.stall_o), 32'd1);
            check("mdl_rst_vld", 32'(bus.jmp_addr_valid_o), 32'd0);
            check("mdl_rst_trap", 32'(bus.trap_o), 32'd0);
            check("mdl_rst_addr", bus.jmp_addr_o, BOOT);
            check("mdl_rst_pc", bus.program_counter_o, BOOT);
            check("mdl_rst_cause", 32'(bus.trap_cause_o), 32'd0);
        end else begin
            bit run, haz, stl, jal, jmis, acc, nxt_trap, was_load, flush, wr;
            bit e_vld;
            logic [31:0] e_addr;
            int newrd;
            run = (m_age >= 2) && !m_load && !m_trap_now;
            wr  = bus.lsu_ctrl_valid_i && bus.lsu_cmd_i[3];
            haz = 0;
            foreach (m_hist[i]) begin
                if (m_hist[i] != 0) begin
                    if (bus.rpa_used_i && int'(bus.rf_addr_a_i) == m_hist[i]) haz = 1;
                    if ((bus.rpb_used_i || wr) && int'(bus.rf_addr_b_i) == m_hist[i]) haz = 1;
                end
            end
            stl  = !run || haz;
            jal  = run && bus.jmp_req_i && (bus.jmp_tgt_i[1:0] == 2'b00);
            jmis = run && bus.jmp_req_i && (bus.jmp_tgt_i[1:0] != 2'b00);
            e_vld  = (m_age == 1) || m_trap_now || jal;
            e_addr = jal ? bus.jmp_tgt_i : m_redir;
            check("mdl_stall", 32'(bus.stall_o), 32'(stl));
            check("mdl_vld", 32'(bus.jmp_addr_valid_o), 32'(e_vld));
            check("mdl_addr", bus.jmp_addr_o, e_addr);
            check("mdl_trap", 32'(bus.trap_o), 32'(m_trap_now));
            check("mdl_pc", bus.program_counter_o, m_pc);
            check("mdl_cause", 32'(bus.trap_cause_o), 32'(m_cause));

            acc = bus.instr_issued_i && !stl;
            was_load = m_load;
            nxt_trap = 0;
            if (m_age == 1) m_redir = BOOT;
            if (jmis) begin
                nxt_trap = 1; m_cause = 2'd1;
            end else if (jal) begin
                m_pc = bus.jmp_tgt_i;
            end else if (acc) begin
                m_pc = m_pc + 32'd4;
                if (bus.lsu_ctrl_valid_i && !wr) begin m_load = 1; m_wait = 0; end
            end
            if (was_load) begin
                if (bus.lsu_ready_i) m_load = 0;
`ifdef RVJ1_LOAD_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait == TMO) begin m_load = 0; nxt_trap = 1; m_cause = 2'd2; end
                end
`endif
            end
            if (nxt_trap) begin m_pc = TRAPA; m_redir = TRAPA; end
            flush = jal || jmis || nxt_trap || m_trap_now;
            newrd = (acc && bus.rd_we_i && bus.rd_addr_i != 0) ? int'(bus.rd_addr_i) : 0;
            m_hist.push_front(newrd);
            if (m_hist.size() > HAZ) void'(m_hist.pop_back());
            if (flush) foreach (m_hist[i]) m_hist[i] = 0;
            m_trap_now = nxt_trap;
            if (m_age < 2) m_age++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.rf_addr_a_i = '0; bus.rf_addr_b_i = '0;
        bus.rpa_used_i = 1'b0; bus.rpb_used_i = 1'b0;
        bus.rd_addr_i = '0; bus.rd_we_i = 1'b0;
        bus.lsu_cmd_i = LSU_LB; bus.lsu_ctrl_valid_i = 1'b0; bus.lsu_ready_i = 1'b0;
        bus.instr_issued_i = 1'b0; bus.jmp_req_i = 1'b0; bus.jmp_tgt_i = '0;
    endtask

    task automatic issue_load();
        idle();
        bus.instr_issued_i = 1'b1; bus.lsu_ctrl_valid_i = 1'b1; bus.lsu_cmd_i = LSU_LW;
        bus.rd_addr_i = 5'd8; bus.rd_we_i = 1'b1;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        smp(); smp();
        check("rst_stall", 32'(bus.stall_o), 32'd1);
        check("rst_vld", 32'(bus.jmp_addr_valid_o), 32'd0);
        check("rst_trap", 32'(bus.trap_o), 32'd0);
        check("rst_addr", bus.jmp_addr_o, 32'h8000_0000);
        check("rst_pc", bus.program_counter_o, 32'h8000_0000);
        check("rst_cause", 32'(bus.trap_cause_o), 32'd0);

        // reset release: RESET, BOOT, RUN
        nxt(); rstn = 1'b1; smp();
        check("rel_c1_stall", 32'(bus.stall_o), 32'd1);
        check("rel_c1_vld", 32'(bus.jmp_addr_valid_o), 32'd0);
        nxt(); smp();
        check("boot_vld", 32'(bus.jmp_addr_valid_o), 32'd1);
        check("boot_addr", bus.jmp_addr_o, 32'h8000_0000);
        check("boot_stall", 32'(bus.stall_o), 32'd1);

        // RAW hazard on x5 via operand A
        nxt(); bus.instr_issued_i = 1'b1; bus.rd_addr_i = 5'd5; bus.rd_we_i = 1'b1; smp();
        check("run_stall", 32'(bus.stall_o), 32'd0);
        check("run_pc", bus.program_counter_o, 32'h8000_0000);
        check("run_vld", 32'(bus.jmp_addr_valid_o), 32'd0);
        nxt(); bus.rd_addr_i = 5'd0; bus.rd_we_i = 1'b0; bus.rf_addr_a_i = 5'd5; bus.rpa_used_i = 1'b1; smp();
        check("haz_a_1", 32'(bus.stall_o), 32'd1);
        nxt(); smp();
        check("haz_a_2", 32'(bus.stall_o), 32'd1);
        nxt(); smp();
        check("haz_a_rel", 32'(bus.stall_o), 32'd0);
        nxt(); bus.rf_addr_a_i = 5'd0; bus.rd_we_i = 1'b1; smp();
        check("x0_stall_a", 32'(bus.stall_o), 32'd0);
        check("pc_after_haz", bus.program_counter_o, 32'h8000_0008);
        nxt(); bus.rd_we_i = 1'b0; smp();
        check("x0_stall_b", 32'(bus.stall_o), 32'd0);

        // store data operand hazard (rpb_used=0 but a store is valid)
        nxt(); bus.rpa_used_i = 1'b0; bus.rd_addr_i = 5'd7; bus.rd_we_i = 1'b1; smp();
        check("st_prod", 32'(bus.stall_o), 32'd0);
        nxt(); bus.rd_addr_i = 5'd0; bus.rd_we_i = 1'b0; bus.rf_addr_b_i = 5'd7;
        bus.lsu_ctrl_valid_i = 1'b1; bus.lsu_cmd_i = LSU_SW; smp();
        check("st_haz_1", 32'(bus.stall_o), 32'd1);
        nxt(); smp();
        check("st_haz_2", 32'(bus.stall_o), 32'd1);
        nxt(); smp();
        check("st_haz_rel", 32'(bus.stall_o), 32'd0);
        nxt(); idle(); smp();
        check("pc_after_st", bus.program_counter_o, 32'h8000_0018);

        // load with ready after 3 wait cycles
        nxt(); issue_load(); smp();
        check("ld_issue", 32'(bus.stall_o), 32'd0);
        nxt(); idle(); smp();
        check("ld_w1", 32'(bus.stall_o), 32'd1);
        nxt(); smp();
        check("ld_w2", 32'(bus.stall_o), 32'd1);
        nxt(); bus.lsu_ready_i = 1'b1; smp();
        check("ld_w3", 32'(bus.stall_o), 32'd1);
        nxt(); bus.lsu_ready_i = 1'b0; smp();
        check("ld_done_stall", 32'(bus.stall_o), 32'd0);
        check("ld_done_trap", 32'(bus.trap_o), 32'd0);
        check("ld_done_pc", bus.program_counter_o, 32'h8000_001C);

        // misaligned jump -> trap cause 1
        nxt(); bus.jmp_req_i = 1'b1; bus.jmp_tgt_i = 32'h8000_0042; smp();
        check("mis_vld", 32'(bus.jmp_addr_valid_o), 32'd0);
        nxt(); idle(); smp();
        check("mis_trap", 32'(bus.trap_o), 32'd1);
        check("mis_cause", 32'(bus.trap_cause_o), 32'd1);
        check("mis_pc", bus.program_counter_o, 32'h8000_0100);
        check("mis_vld_t", 32'(bus.jmp_addr_valid_o), 32'd1);
        check("mis_addr", bus.jmp_addr_o, 32'h8000_0100);
        nxt(); smp();
        check("mis_after", 32'(bus.trap_o), 32'd0);

        // aligned jump with simultaneous issue: target wins
        nxt(); bus.jmp_req_i = 1'b1; bus.jmp_tgt_i = 32'h8000_0040; bus.instr_issued_i = 1'b1; smp();
        check("jmp_vld", 32'(bus.jmp_addr_valid_o), 32'd1);
        check("jmp_addr", bus.jmp_addr_o, 32'h8000_0040);
        nxt(); idle(); smp();
        check("jmp_pc", bus.program_counter_o, 32'h8000_0040);

        // PC wrap
        nxt(); bus.jmp_req_i = 1'b1; bus.jmp_tgt_i = 32'hFFFF_FFFC;
        nxt(); idle(); bus.instr_issued_i = 1'b1; smp();
        check("wrap_pre", bus.program_counter_o, 32'hFFFF_FFFC);
        nxt(); idle(); smp();
        check("wrap_pc", bus.program_counter_o, 32'h0000_0000);

        // load with no ready; jump during wait must be ignored
        nxt(); issue_load(); smp();
        nxt(); idle(); bus.jmp_req_i = 1'b1; bus.jmp_tgt_i = 32'h0000_0100; smp();
        check("ldw_jmp_ign", 32'(bus.jmp_addr_valid_o), 32'd0);
        bus.jmp_req_i = 1'b0;
`ifdef RVJ1_LOAD_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            nxt(); smp();
            check("tmo_wait", 32'(bus.trap_o), 32'd0);
        end
        nxt(); smp();
        check("tmo_trap", 32'(bus.trap_o), 32'd1);
        check("tmo_cause", 32'(bus.trap_cause_o), 32'd2);
        check("tmo_addr", bus.jmp_addr_o, 32'h8000_0100);
        check("tmo_pc", bus.program_counter_o, 32'h8000_0100);
        nxt(); smp();
        check("tmo_run", 32'(bus.stall_o), 32'd0);
`else
        for (int k = 1; k < 100; k++) begin
            nxt(); smp();
            check("noto_stall", 32'(bus.stall_o), 32'd1);
        end
        nxt(); bus.lsu_ready_i = 1'b1; smp();
        check("noto_rdy", 32'(bus.stall_o), 32'd1);
        nxt(); bus.lsu_ready_i = 1'b0; smp();
        check("noto_run", 32'(bus.stall_o), 32'd0);
        check("noto_cause", 32'(bus.trap_cause_o), 32'd1);
`endif

        // ready arriving on the timeout cycle wins
        nxt(); issue_load(); smp();
        for (int k = 0; k < 16; k++) begin
            nxt(); idle(); if (k == 15) bus.lsu_ready_i = 1'b1; smp();
        end
        nxt(); idle(); smp();
        check("race_trap", 32'(bus.trap_o), 32'd0);
        check("race_stall", 32'(bus.stall_o), 32'd0);

        // reset in the middle of a load
        nxt(); issue_load(); smp();
        nxt(); idle(); smp();
        nxt(); smp();
        nxt(); rstn = 1'b0; smp();
        check("mid_rst_stall", 32'(bus.stall_o), 32'd1);
        check("mid_rst_pc", bus.program_counter_o, 32'h8000_0000);
        check("mid_rst_cause", 32'(bus.trap_cause_o), 32'd0);
        nxt(); smp();
        nxt(); rstn = 1'b1; smp();
        nxt(); smp();
        check("mid_boot_vld", 32'(bus.jmp_addr_valid_o), 32'd1);
        nxt(); smp();
        check("mid_run_stall", 32'(bus.stall_o), 32'd0);
        check("mid_run_trap", 32'(bus.trap_o), 32'd0);

        nxt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rvj1_pipe_ctrl.md
RVJ1_PIPE_CTRL -- requirements
Module: rvj1_pipe_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- BOOT_ADDR, 32'h8000_0000, first fetch address after reset.
- TRAP_ADDR, 32'h8000_0100, redirect target on any trap.
- HAZ_DEPTH, 2, number of in-flight destination registers tracked (legal 1..4).
- LOAD_TIMEOUT, 16, cycles to wait for lsu_ready_i (legal 2..255).

REQ-002 The block SHALL have these ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset: one clock; reset is asynchronous and active-low.
- rf_addr_a_i / rf_addr_b_i  in  RALEN  source register addresses.
- rpa_used_i / rpb_used_i  in  1  operand A/B is read from the register file.
- rd_addr_i  in  RALEN  destination register of the issuing instruction.
- rd_we_i  in  1  issuing instruction writes rd.
- lsu_cmd_i  in  lsu_ctrl_e  LSU command; bit 3 means write.
- lsu_ctrl_valid_i  in  1  LSU command valid.
- lsu_ready_i  in  1  LSU data ready.
- instr_issued_i  in  1  decoder issues an instruction this cycle.
- jmp_req_i  in  1  ALU requests a redirect.
- jmp_tgt_i  in  XLEN  redirect target.
- stall_o  out  1  hold decode/issue.
- program_counter_o  out  XLEN  current PC.
- jmp_addr_valid_o  out  1  fetch redirect strobe.
- jmp_addr_o  out  XLEN  fetch redirect address.
- trap_o  out  1  one-cycle trap pulse.
- trap_cause_o  out  2  trap cause, held until the next trap.

Function
REQ-003 The FSM SHALL have states RESET, BOOT, RUN, LOAD_WAIT and TRAP, with these transitions:
- RESET->BOOT.
- BOOT->RUN.
- RUN->LOAD_WAIT on an issued load (instr_issued_i && lsu_ctrl_valid_i && !lsu_cmd_i[3]).
- LOAD_WAIT->RUN on lsu_ready_i.
- RUN->TRAP on a misaligned jump.
- LOAD_WAIT->TRAP on timeout.
- TRAP->RUN.
REQ-004 In BOOT, jmp_addr_valid_o SHALL be 1 for exactly one cycle with jmp_addr_o=BOOT_ADDR.
REQ-005 The scoreboard SHALL be a HAZ_DEPTH-entry shift register of {valid, rd}, shifting every cycle. It SHALL insert {rd_we_i && rd_addr_i!=0, rd_addr_i} when an issue is accepted, and an invalid entry otherwise.
REQ-006 stall_o SHALL be 1 (combinationally) when any of the following holds:
- a valid scoreboard entry equals a nonzero rf_addr_a_i and rpa_used_i=1;
- a valid scoreboard entry equals a nonzero rf_addr_b_i and either rpb_used_i=1 or a store is valid;
- the state is RESET, BOOT, LOAD_WAIT or TRAP.
REQ-007 instr_issued_i asserted while stall_o=1 SHALL be ignored: no PC change and no scoreboard insert.
REQ-008 An accepted issue SHALL advance the PC by 4 (mod 2^XLEN, so 32'hFFFF_FFFC wraps to 0).
REQ-009 A jmp_req_i with jmp_tgt_i[1:0]==0 SHALL take effect in the same cycle:
- jmp_addr_valid_o=1 and jmp_addr_o=jmp_tgt_i;
- the PC loads jmp_tgt_i on the next edge;
- the scoreboard is flushed.
REQ-010 A jmp_req_i with a simultaneous accepted issue SHALL win: the PC loads the target, not PC+4.
REQ-011 A jmp_req_i with jmp_tgt_i[1:0]!=0 SHALL enter TRAP with cause 2'd1 (misaligned) instead of redirecting.
REQ-012 Entry into TRAP SHALL cause, in the TRAP cycle:
- trap_o=1;
- jmp_addr_valid_o=1 and jmp_addr_o=TRAP_ADDR;
- the PC loads TRAP_ADDR;
- the scoreboard is flushed.
REQ-013 The load timeout counter SHALL clear on LOAD_WAIT entry and increment each LOAD_WAIT cycle. Reaching LOAD_TIMEOUT without lsu_ready_i SHALL enter TRAP with cause 2'd2.
REQ-014 lsu_ready_i in the same cycle the timeout is reached SHALL win (go to RUN, no trap).
REQ-015 jmp_req_i outside RUN SHALL be ignored.

Reset
REQ-016 While rstn_i=0, the block SHALL asynchronously force:
- state=RESET;
- PC=BOOT_ADDR;
- scoreboard invalid;
- timeout counter=0;
- trap_cause_o=0.
REQ-017 During and immediately after reset, the outputs SHALL be:
- stall_o=1;
- jmp_addr_valid_o=0 and trap_o=0;
- jmp_addr_o=BOOT_ADDR.
REQ-018 Reset asserted in any state, including mid-load, SHALL abort the operation with no trap.

Configuration
REQ-019 With macro RVJ1_LOAD_TIMEOUT_EN defined, the timeout counter and cause 2'd2 SHALL exist as described.
REQ-020 Without RVJ1_LOAD_TIMEOUT_EN, the counter SHALL be absent, LOAD_WAIT SHALL exit only on lsu_ready_i, and cause 2'd2 SHALL never occur. LOAD_TIMEOUT is then ignored.

Structure
REQ-021 rvj1_defines SHALL hold XLEN, RALEN, lsu_ctrl_e, the FSM enum rvj1_ctrl_fsm_e and the trap cause enum trap_cause_e (NONE=0, MISALIGN=1, LD_TIMEOUT=2).
REQ-022 The scoreboard SHALL be the sub-module rvj1_scoreboard, parametrised by HAZ_DEPTH, with a flush input and a hazard output.

Verification
REQ-023 Reset release: jmp_addr_valid_o pulses exactly once with 32'h8000_0000, stall_o falls on the third cycle, and PC=32'h8000_0000.
REQ-024 HAZ_DEPTH=2: issue rd=x5, then rs1=x5 with rpa_used=1 -> stall for 2 cycles then release. With rs1=x0 -> no stall.
REQ-025 Load issued and lsu_ready_i after 3 cycles -> stall 3 cycles, return to RUN, no trap.
REQ-026 With RVJ1_LOAD_TIMEOUT_EN, LOAD_TIMEOUT=16 and no ready -> trap_o on cycle 16, cause=2, jmp_addr_o=32'h8000_0100. Without the macro -> stall held for 100 cycles, no trap.
REQ-027 jmp_req_i with target 32'h8000_0042 -> trap, cause=1, PC=32'h8000_0100. Target 32'h8000_0040 together with instr_issued_i -> PC=32'h8000_0040.
REQ-028 PC=32'hFFFF_FFFC plus an accepted issue -> PC=0.
